serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial multi-bit subtractor controller. Computes `a - b` for `WIDTH`-bit unsigned operands, one bit per clock, LSB first. Each bit step runs through a single full-subtractor cell built from two half-subtractor stages. The block adds the start/done handshake, operand capture, bit counter and result register needed to use the combinational subtractor cells as a shared, sequenced arithmetic resource.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a subtraction. Sampled only in IDLE.
- `a`  in  WIDTH: minuend. Captured on the accepting edge.
- `b`  in  WIDTH: subtrahend. Captured on the accepting edge.
- `busy`  out  1: high in SHIFT and DONE.
- `done`  out  1: one-cycle pulse when the result is valid.
- `diff`  out  WIDTH: result `(a - b) mod 2^WIDTH`. Held until the next `done`.
- `borrow_out`  out  1: final borrow. High when `a < b` (unsigned). Held with `diff`.
- `ovf`  out  1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `start=1` latches `a` and `b` into shift registers.
  - Clears the borrow flop and the bit counter.
  - Next state is SHIFT.
  - `start=0` stays in IDLE.
- **SHIFT:** each cycle, the bit cell takes operand LSBs plus the stored borrow and produces a difference bit and a borrow.
  - The difference bit shifts into the MSB of the internal accumulator.
  - The operands shift right.
  - The borrow is registered and the counter increments.
  - When the counter reaches `WIDTH-1`, the next state is DONE.
- **DONE (exactly one cycle):**
  - `done=1`.
  - `diff` and `borrow_out` are loaded from the accumulator and final borrow on entry to DONE, so they are valid throughout the DONE cycle.
  - Next state is IDLE.
- **`start` outside IDLE** is ignored. It is neither queued nor does it corrupt the operation in flight.
- **Operand inputs** may change freely after the accepting edge.
- **Counter width** is `$clog2(WIDTH)`. The counter never wraps past `WIDTH-1`.
- **Reset** (any time, including mid-SHIFT):
  - State returns to IDLE.
  - `busy`, `done`, `borrow_out` and `ovf` are 0, and `diff` is 0.
  - Internal shift registers, counter and borrow are cleared.
  - The in-flight operation is discarded, with no `done`.

## Timing
- **Cycle 0:** edge with `start=1` in IDLE (the accepting edge).
- **Cycles 1..WIDTH:** SHIFT, with `busy=1`.
- **Cycle WIDTH+1:** DONE, with `done=1`, `busy=1`, and results valid.
- **Cycle WIDTH+2:** IDLE. A new `start` is accepted here at the earliest.
- **Latency:** WIDTH+1 cycles from the accepting edge to `done` high.
- **Throughput:** one operation per WIDTH+2 cycles.
- **Outputs:** all registered, with no combinational path from inputs to outputs.

## Configuration
- **Macro `SERIAL_SUB_OVF_EN`:**
  - **Defined:**
    - The `ovf` port exists.
    - `ovf` = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]), using the captured operand sign bits.
    - It is registered alongside `diff`, has the same hold and reset behaviour, and is valid from DONE.
  - **Undefined:** the port, the sign-capture flops and the logic are absent. All other behaviour is identical.

## Structure
- **Shared package `serial_sub_pkg`:**
  - State enum `sub_state_t` (IDLE, SHIFT, DONE).
  - Default-width constant `SUB_WIDTH_DEFAULT = 8`.
- **Sub-module `full_sub_bit`:** combinational `x, y, bin -> d, bout`, composed of two half-subtractor stages plus an OR of their borrows. It is instantiated once and reused every SHIFT cycle.
- **Local to `serial_sub_ctrl`:** counter width localparam and all sequential logic.

## Test plan
- **Basic subtraction:** WIDTH=8, `a=5`, `b=3`, one `start` pulse.
  - `done` goes high exactly 9 cycles after the accepting edge, with `diff=0x02` and `borrow_out=0`.
  - `busy` is high for 9 cycles.
- **Borrow case:** `a=3`, `b=5`.
  - `diff=0xFE`, `borrow_out=1`.
  - `a=0`, `b=0` gives `diff=0x00`, `borrow_out=0`.
  - `a=0xFF`, `b=0xFF` gives `diff=0x00`.
- **Start during busy:** start `a=9`, `b=4`. Hold `start=1` and change `a=0x77` during SHIFT.
  - Exactly one `done`, with `diff=0x05`.
  - A second op is accepted only in the cycle after DONE.
- **Reset mid-operation:** start `a=0x40`, `b=0x01`, then assert `rst_n=0` at SHIFT cycle 4.
  - All outputs are 0 immediately (asynchronously).
  - After release, the block is in IDLE and no `done` fires.
  - A fresh op `a=0x10`, `b=0x01` yields `diff=0x0F`.
- **Overflow flag** (`SERIAL_SUB_OVF_EN` defined):
  - `a=0x80`, `b=0x01` gives `diff=0x7F`, `ovf=1`.
  - `a=0x7F`, `b=0xFF` gives `diff=0x80`, `ovf=1`.
  - `a=0x10`, `b=0x01` gives `ovf=0`.
- **Back-to-back and result hold:**
  - Two ops started at the earliest legal cycles complete at cycles 9 and 19 (10-cycle spacing).
  - `diff` holds its value between them.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } sub_state_t;

endpackage

// File: rtl/full_sub_bit.sv
// Combinational full subtractor: x - y - bin, built from two half-subtractor stages.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1, b1, b2;

  // First stage x - y, second stage subtracts the incoming borrow.
  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller, LSB first, one bit per clock through a shared full_sub_bit.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_b;
  logic [WIDTH-1:0] acc_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_sgn_q, a_sgn_d;
  logic b_sgn_q, b_sgn_d;
  logic ovf_q, ovf_d;
`endif

  full_sub_bit u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_b)
  );

  assign acc_next = {cell_d, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    brw_d  = brw_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_sgn_d = a_sgn_q;
    b_sgn_d = b_sgn_q;
    ovf_d   = ovf_q;
`endif
    if (state_q == StIdle && start) begin
      a_sh_d = a;
      b_sh_d = b;
      acc_d  = '0;
      cnt_d  = '0;
      brw_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_d = a[WIDTH-1];
      b_sgn_d = b[WIDTH-1];
`endif
    end else if (state_q == StShift) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      acc_d  = acc_next;
      brw_d  = cell_b;
      if (cnt_q != CntLast) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // Last bit: publish results so they are valid for the whole DONE cycle.
        diff_d = acc_next;
        bout_d = cell_b;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d = (a_sgn_q != b_sgn_q) && (acc_next[WIDTH-1] != a_sgn_q);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      brw_q  <= brw_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sgn_q <= 1'b0;
      b_sgn_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_sgn_q <= a_sgn_d;
      b_sgn_q <= b_sgn_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl against an arithmetic reference model.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a_in),
    .b          (b_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r += (1 << W);
    return W'(r);
  endfunction

  function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

`ifdef SERIAL_SUB_OVF_EN
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
    sy = (int'(y) >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction
`endif

  // One operation: x_late is driven onto a after acceptance; hold keeps start high while busy.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] x_late, input bit hold, input string tag);
    int n;
    int busy_n;
    n = 0;
    busy_n = 0;
    @(negedge clk);
    start = 1'b1;
    a_in = x;
    b_in = y;
    @(posedge clk);
    #1;
    if (busy) busy_n++;
    @(negedge clk);
    if (!hold) start = 1'b0;
    a_in = x_late;
    b_in = W'($urandom);
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_n++;
      if (done) break;
    end
    start = 1'b0;
    check_val({tag, ":lat"}, n + 1, W + 1);
    check_val({tag, ":busy"}, busy_n, W + 1);
    check_val({tag, ":diff"}, diff, model_diff(x, y));
    check_val({tag, ":brw"}, borrow_out, model_borrow(x, y));
`ifdef SERIAL_SUB_OVF_EN
    check_val({tag, ":ovf"}, ovf, model_ovf(x, y));
`endif
    @(posedge clk);
    #1;
    check_val({tag, ":idle"}, {busy, done}, 0);
  endtask

  initial begin
    int ndone, k, k1, k2, hold_bad;
    logic [W-1:0] d1, d2, ra, rb;

    #1;
    check_val("rst_outs", {busy, done, borrow_out}, 0);
    check_val("rst_diff", diff, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd5, 8'd3, 8'd5, 1'b0, "basic");
    run_op(8'd3, 8'd5, 8'd3, 1'b0, "borrow");
    run_op(8'd0, 8'd0, 8'hAA, 1'b0, "zero");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "ffff");
    run_op(8'h80, 8'h01, 8'h00, 1'b0, "ovf_a");
    run_op(8'h7F, 8'hFF, 8'h00, 1'b0, "ovf_b");

    // start held through the op and a changed mid-flight
    run_op(8'd9, 8'd4, 8'h77, 1'b1, "hold");
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check_val("hold:extra_done", ndone, 0);

    // reset in the middle of SHIFT
    run_op(8'd5, 8'd3, 8'd0, 1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1;
    a_in = 8'h40;
    b_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_outs", {busy, done, borrow_out}, 0);
    check_val("mid_rst_diff", diff, 0);
`ifdef SERIAL_SUB_OVF_EN
    check_val("mid_rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    check_val("post_rst_quiet", ndone, 0);
    run_op(8'h10, 8'h01, 8'h33, 1'b0, "post_rst");

    // back-to-back with start held continuously
    ra = W'($urandom);
    rb = W'($urandom);
    @(negedge clk);
    start = 1'b1;
    a_in = 8'hC3;
    b_in = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    a_in = ra;
    b_in = rb;
    ndone = 0;
    k1 = 0;
    k2 = 0;
    hold_bad = 0;
    d1 = '0;
    d2 = '0;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          k1 = k;
          d1 = diff;
        end else begin
          k2 = k;
          d2 = diff;
          start = 1'b0;
          break;
        end
      end else if (ndone == 1 && diff !== d1) begin
        hold_bad++;
      end
    end
    start = 1'b0;
    check_val("b2b:cyc1", k1 + 1, 9);
    check_val("b2b:cyc2", k2 + 1, 19);
    check_val("b2b:diff1", d1, model_diff(8'hC3, 8'h5A));
    check_val("b2b:diff2", d2, model_diff(ra, rb));
    check_val("b2b:hold", hold_bad, 0);
    @(posedge clk);
    #1;
    check_val("b2b:idle", {busy, done}, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
